sbox_replacer: RTL and testbench
================================

# sbox_replacer

Nibble-wise substitution (S-box) stage of the GOST R 34.12-2015 "Magma" round function. It maps an R_WIDTH-bit word through eight fixed 4-bit substitution tables. The round unit feeds it (right half + round key mod 2^R_WIDTH), then rotates the result left by 11 and XORs it into the left half. The data path is combinational by default, with an optional registered output stage for timing closure.

## Interface
Parameters:
- R_WIDTH, 32, word width; must be a positive multiple of 4 (elaboration error otherwise).
- OUT_REG, 0, 0 = purely combinational output; 1 = one register stage.

Ports:
- clk_i  input  1  clock; one clock domain.
- aresetn_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  qualifies data_i (used only when OUT_REG=1).
- data_i  input  R_WIDTH  word to substitute.
- data_o  output  R_WIDTH  substituted word.
- valid_o  output  1  qualifies data_o.

## Operation
- Nibble i is data_i[4i+3:4i]. Output nibble i = PI[i mod 8][nibble i]. Nibble 0 is the least significant.
- Tables, entries listed for index 0..F in hex:
  - PI0: C 4 6 2 A 5 B 9 E 8 D 7 0 3 F 1
  - PI1: 6 8 2 3 9 A 5 C 1 E 4 7 B D 0 F
  - PI2: B 3 5 8 2 F A D E 1 7 4 C 9 6 0
  - PI3: C 8 2 1 D 4 F 6 7 0 A 5 3 E 9 B
  - PI4: 7 F 5 A 8 1 6 D 0 9 3 E B 4 2 C
  - PI5: 5 D F 6 9 2 C A B 7 8 1 4 3 E 0
  - PI6: 8 E 2 5 6 9 1 C F 4 B 0 D A 3 7
  - PI7: 1 7 E D 0 5 8 3 4 F A 6 9 C B 2
- No arithmetic. Each nibble is an independent pure lookup; no cross-nibble carries.

## Timing
- OUT_REG=0:
  - data_o = S(data_i) combinationally, zero latency.
  - valid_o = valid_i.
  - Clock and reset are unused; no state exists.
- OUT_REG=1:
  - On each rising clk_i, data_o <= S(data_i) and valid_o <= valid_i. Latency is exactly 1 cycle.
  - The register loads unconditionally every cycle; there is no stall or enable.
- Reset (OUT_REG=1): asserting aresetn_i low immediately forces data_o = 0 and valid_o = 0, without waiting for a clock edge. This applies even mid-stream.
- After reset release, the first rising edge captures the current input.
- The output glitches only while data_i changes (OUT_REG=0). The consumer must sample on a clock edge.

## Structure
- Shared package holds:
  - the eight 16-entry 4-bit tables as a constant array PI[8][16];
  - the Magma constants R_WIDTH=32 and SHIFT_VAL=11, for reuse by the round unit.
- One natural sub-module: sbox4 (4-bit in, 4-bit out, table index parameter 0..7). It is instantiated R_WIDTH/4 times via generate.
- The optional output register lives in the top level.

## Test plan
- Standard vector chain, OUT_REG=0. Each of the following must hold in the same delta:
  - 0xfdb97531 -> 0x2a196f34
  - 0x2a196f34 -> 0xebd9f03a
  - 0xebd9f03a -> 0xb039bb3d
  - 0xb039bb3d -> 0x68695433
- Corner words: 0x00000000 -> 0x1857cb6c; 0xffffffff -> 0x270cb0f1.
- Exhaustive per-nibble sweep: for each position i and value v (0..F), with other nibbles 0, output nibble i = PI[i][v] and other nibbles are unchanged from the all-zero result.
- OUT_REG=1 latency: drive 0xfdb97531 with valid_i=1 for one cycle, then 0 with valid_i=0. data_o = 0x2a196f34 and valid_o=1 exactly one cycle later, then 0x1857cb6c with valid_o=0.
- Reset mid-operation (OUT_REG=1): while data_o=0x68695433 and valid_o=1, pull aresetn_i low between edges. data_o=0 and valid_o=0 immediately, and they hold while reset is low. The first edge after release loads S(data_i).
- R_WIDTH=64: 0xfdb97531fdb97531 -> 0x2a196f342a196f34 (tables repeat every 8 nibbles).

Source files
------------

// File: rtl/sbox_replacer_pkg.sv
// rtl/sbox_replacer_pkg.sv - Magma S-box tables and round constants
package sbox_replacer_pkg;

  // Magma round geometry, shared with the round unit
  localparam int unsigned R_WIDTH   = 32;
  localparam int unsigned SHIFT_VAL = 11;

  // Nibble geometry of the substitution layer
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned N_TABLES  = 8;

  // PI[t][v]: table t applied to nibble positions t, t+8, t+16, ...
  localparam logic [3:0] PI [0:7][0:15] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9,
      4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC,
      4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD,
      4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6,
      4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD,
      4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA,
      4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC,
      4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3,
      4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

endpackage

// File: rtl/sbox_replacer_if.sv
// rtl/sbox_replacer_if.sv - data/valid bundle between round unit and S-box stage
interface sbox_replacer_if
  import sbox_replacer_pkg::*;
#(
  parameter int W = sbox_replacer_pkg::R_WIDTH
);

  logic         valid_i;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic [W-1:0] data_o;

  // Producer side: drives the word to substitute, observes the result
  modport master (
    output valid_i,
    output data_i,
    input  valid_o,
    input  data_o
  );

  // S-box stage side
  modport slave (
    input  valid_i,
    input  data_i,
    output valid_o,
    output data_o
  );

endinterface

// File: rtl/sbox_replacer_sbox4.sv
// rtl/sbox_replacer_sbox4.sv - single 4-bit Magma substitution lookup
module sbox_replacer_sbox4
  import sbox_replacer_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  if (IDX >= N_TABLES) begin : g_bad_idx
    $error("sbox_replacer_sbox4: IDX must be 0..7");
  end

  // Pure table lookup; IDX is constant so only the 16:1 mux remains
  assign nib_o = PI[IDX][nib_i];

endmodule

// File: rtl/sbox_replacer.sv
// rtl/sbox_replacer.sv - Magma nibble-wise S-box layer with optional output register
module sbox_replacer
  import sbox_replacer_pkg::*;
#(
  parameter int R_WIDTH = sbox_replacer_pkg::R_WIDTH,
  parameter bit OUT_REG = 1'b0
) (
  input  logic           clk_i,
  input  logic           aresetn_i,
  sbox_replacer_if.slave bus
);

  localparam int N_NIB = R_WIDTH / 4;

  if (R_WIDTH <= 0 || (R_WIDTH % 4) != 0) begin : g_bad_width
    $error("sbox_replacer: R_WIDTH must be a positive multiple of 4");
  end

  logic [R_WIDTH-1:0] data_d;
  logic               valid_d;

  // Each nibble is independent; tables repeat every eight nibbles
  for (genvar g = 0; g < N_NIB; g++) begin : g_nib
    sbox_replacer_sbox4 #(
      .IDX (g % 8)
    ) u_sbox4 (
      .nib_i (bus.data_i[4*g +: 4]),
      .nib_o (data_d[4*g +: 4])
    );
  end

  assign valid_d = bus.valid_i;

  if (OUT_REG) begin : g_reg
    logic [R_WIDTH-1:0] data_q;
    logic               valid_q;

    // Unconditional output register; async reset clears it mid-stream too
    always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
  end else begin : g_comb
    // Combinational build has no state, so clock and reset are sunk here
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk_i, aresetn_i};

    assign bus.data_o  = data_d;
    assign bus.valid_o = valid_d;
  end

endmodule

// File: tb/tb_sbox_replacer.sv
// tb/tb_sbox_replacer.sv - directed-vector bench for sbox_replacer
module tb_sbox_replacer;

  logic clk;
  logic aresetn;

  int n_checks = 0;
  int n_errors = 0;

  // Reference tables, copied by hand from the algorithm definition
  localparam logic [3:0] PI_REF [0:7][0:15] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

  sbox_replacer_if #(.W(32)) bus_c ();
  sbox_replacer_if #(.W(32)) bus_r ();
  sbox_replacer_if #(.W(64)) bus_w ();

  sbox_replacer #(.R_WIDTH(32), .OUT_REG(1'b0)) dut_c (
    .clk_i     (clk),
    .aresetn_i (aresetn),
    .bus       (bus_c)
  );

  sbox_replacer #(.R_WIDTH(32), .OUT_REG(1'b1)) dut_r (
    .clk_i     (clk),
    .aresetn_i (aresetn),
    .bus       (bus_r)
  );

  sbox_replacer #(.R_WIDTH(64), .OUT_REG(1'b0)) dut_w (
    .clk_i     (clk),
    .aresetn_i (aresetn),
    .bus       (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic comb_vec(input string tag, input logic [31:0] din, input logic [31:0] dexp);
    bus_c.data_i  = din;
    bus_c.valid_i = 1'b1;
    #1;
    check(tag, {32'h0, bus_c.data_o}, {32'h0, dexp});
  endtask

  initial begin
    logic [31:0] zero_res;
    logic [31:0] exp_w;

    aresetn       = 1'b0;
    bus_c.data_i  = '0;
    bus_c.valid_i = 1'b0;
    bus_r.data_i  = '0;
    bus_r.valid_i = 1'b0;
    bus_w.data_i  = '0;
    bus_w.valid_i = 1'b0;

    #12;
    // Registered instance held in reset across an edge
    check("reset_data", {32'h0, bus_r.data_o}, 64'h0);
    check("reset_valid", {63'h0, bus_r.valid_o}, 64'h0);

    // Combinational chain and valid passthrough
    comb_vec("chain0", 32'hfdb97531, 32'h2a196f34);
    comb_vec("chain1", 32'h2a196f34, 32'hebd9f03a);
    comb_vec("chain2", 32'hebd9f03a, 32'hb039bb3d);
    comb_vec("chain3", 32'hb039bb3d, 32'h68695433);
    check("comb_valid1", {63'h0, bus_c.valid_o}, 64'h1);
    bus_c.valid_i = 1'b0;
    #1;
    check("comb_valid0", {63'h0, bus_c.valid_o}, 64'h0);
    comb_vec("zero_word", 32'h00000000, 32'h1857cb6c);
    comb_vec("ones_word", 32'hffffffff, 32'h270cb0f1);

    // Per-nibble sweep against the all-zero result
    zero_res = 32'h1857cb6c;
    for (int i = 0; i < 8; i++) begin
      for (int v = 0; v < 16; v++) begin
        logic [31:0] din;
        din = '0;
        din[4*i +: 4] = 4'(v);
        exp_w = zero_res;
        exp_w[4*i +: 4] = PI_REF[i][v];
        comb_vec($sformatf("sweep_n%0d_v%0h", i, v), din, exp_w);
      end
    end

    // 64-bit build: tables repeat every eight nibbles
    bus_w.data_i = 64'hfdb97531fdb97531;
    #1;
    check("w64_chain0", bus_w.data_o, 64'h2a196f342a196f34);
    bus_w.data_i = 64'h0;
    #1;
    check("w64_zero", bus_w.data_o, 64'h1857cb6c1857cb6c);

    // Registered build: release reset, first edge captures current input
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    check("reg_first_data", {32'h0, bus_r.data_o}, {32'h0, 32'h1857cb6c});
    check("reg_first_valid", {63'h0, bus_r.valid_o}, 64'h0);

    @(negedge clk);
    bus_r.data_i  = 32'hfdb97531;
    bus_r.valid_i = 1'b1;
    #1;
    check("reg_no_early", {32'h0, bus_r.data_o}, {32'h0, 32'h1857cb6c});
    @(posedge clk);
    #1;
    check("reg_lat_data", {32'h0, bus_r.data_o}, {32'h0, 32'h2a196f34});
    check("reg_lat_valid", {63'h0, bus_r.valid_o}, 64'h1);
    bus_r.data_i  = '0;
    bus_r.valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("reg_next_data", {32'h0, bus_r.data_o}, {32'h0, 32'h1857cb6c});
    check("reg_next_valid", {63'h0, bus_r.valid_o}, 64'h0);

    // Mid-stream asynchronous reset
    bus_r.data_i  = 32'hb039bb3d;
    bus_r.valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_data", {32'h0, bus_r.data_o}, {32'h0, 32'h68695433});
    check("pre_rst_valid", {63'h0, bus_r.valid_o}, 64'h1);
    #1;
    aresetn = 1'b0;
    #1;
    check("async_rst_data", {32'h0, bus_r.data_o}, 64'h0);
    check("async_rst_valid", {63'h0, bus_r.valid_o}, 64'h0);
    @(posedge clk);
    #1;
    check("rst_hold_data", {32'h0, bus_r.data_o}, 64'h0);
    check("rst_hold_valid", {63'h0, bus_r.valid_o}, 64'h0);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("rel_no_early", {32'h0, bus_r.data_o}, 64'h0);
    @(posedge clk);
    #1;
    check("rel_first_data", {32'h0, bus_r.data_o}, {32'h0, 32'h68695433});
    check("rel_first_valid", {63'h0, bus_r.valid_o}, 64'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
